// File: rtl/nubus_pkg.sv
// Shared constants and types for the NuBus slave responder.
package nubus_pkg;

  localparam logic [1:0] STATUS_COMPLETE = 2'b00;
  localparam logic [1:0] STATUS_ERROR    = 2'b01;
  localparam logic [1:0] STATUS_TRYAGAIN = 2'b11;

  localparam logic [3:0] SLOT_PREFIX = 4'hF;

  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StWdata = 2'd1;
  localparam state_t StReq   = 2'd2;
  localparam state_t StAck   = 2'd3;

  typedef enum logic [2:0] {
    XferWord,
    XferHalfLo,
    XferHalfHi,
    XferByte,
    XferReserved
  } xfer_t;

endpackage

// File: rtl/nubus_xfer_decode.sv
// Maps NuBus transfer mode and low address bits to direction, byte enables and
// the reserved-encoding flag.
module nubus_xfer_decode
  import nubus_pkg::*;
(
  input  logic       tm1,
  input  logic       tm0,
  input  logic [1:0] lane,
  output logic       is_read,
  output logic [3:0] be,
  output logic       reserved
);

  xfer_t xfer;

  always_comb begin
    xfer = XferReserved;
    if (tm0) begin
      xfer = XferByte;
    end else begin
      unique case (lane)
        2'b00:   xfer = XferWord;
        2'b10:   xfer = XferHalfLo;
        2'b11:   xfer = XferHalfHi;
        default: xfer = XferReserved;
      endcase
    end
  end

  always_comb begin
    is_read  = tm1;
    reserved = 1'b0;
    be       = 4'h0;
    unique case (xfer)
      XferWord:   be = 4'hF;
      XferHalfLo: be = 4'h3;
      XferHalfHi: be = 4'hC;
      XferByte:   be = 4'b0001 << lane;
      default:    reserved = 1'b1;
    endcase
  end

endmodule

// File: rtl/nubus_slave_responder.sv
// Slave-side NuBus cycle engine: decodes slot/superslot accesses, issues one local
// request per transaction and drives the ACK/status/read-data response.
module nubus_slave_responder
  import nubus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES   = 192,
  parameter bit          ENABLE_SUPERSLOT = 1'b1,
  parameter int unsigned LOC_ADDR_W       = 24
) (
  input  logic                  nubus_clk,
  input  logic                  nubus_reset_n,
  input  logic [3:0]            id_n,
  input  logic                  start_n,
  input  logic                  ack_n,
  input  logic                  tm1_n,
  input  logic                  tm0_n,
  input  logic [31:0]           ad_n,
  output logic                  ack_o_n,
  output logic                  tm1_o_n,
  output logic                  tm0_o_n,
  output logic                  tmoen,
  output logic [31:0]           ad_o_n,
  output logic                  ad_oe_n,
  output logic                  loc_valid,
  output logic                  loc_we,
  output logic [LOC_ADDR_W-1:0] loc_addr,
  output logic [31:0]           loc_wdata,
  output logic [3:0]            loc_be,
  input  logic                  loc_ready,
  input  logic [31:0]           loc_rdata,
  input  logic                  loc_err,
  output logic                  loc_abort
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  logic [31:0] addr;
  logic [3:0]  id;
  logic        slot_match, super_match, match;
  logic        dec_is_read, dec_reserved;
  logic [3:0]  dec_be;

  assign addr        = ~ad_n;
  assign id          = ~id_n;
  assign slot_match  = (addr[31:24] == {SLOT_PREFIX, id});
  assign super_match = ENABLE_SUPERSLOT && (addr[31:28] == id);
  assign match       = slot_match | super_match;

  nubus_xfer_decode u_decode (
    .tm1      (~tm1_n),
    .tm0      (~tm0_n),
    .lane     (addr[1:0]),
    .is_read  (dec_is_read),
    .be       (dec_be),
    .reserved (dec_reserved)
  );

  state_t                state_q, state_d;
  logic                  is_read_q, is_read_d;
  logic [3:0]            be_q, be_d;
  logic [LOC_ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            status_q, status_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  abort_q, abort_d;

  always_comb begin
    state_d   = state_q;
    is_read_d = is_read_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    status_d  = status_q;
    cnt_d     = cnt_q;
    abort_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // START with ACK also low is an attention cycle, not a transaction.
        if (!start_n && ack_n && match) begin
          addr_d    = addr[LOC_ADDR_W+1:2];
          be_d      = dec_be;
          is_read_d = dec_is_read;
          status_d  = STATUS_COMPLETE;
          cnt_d     = '0;
          if (dec_reserved) begin
            is_read_d = 1'b0;
            status_d  = STATUS_ERROR;
            state_d   = StAck;
          end else if (dec_is_read) begin
            state_d = StReq;
          end else begin
            state_d = StWdata;
          end
        end
      end
      StWdata: begin
        wdata_d = addr;
        cnt_d   = '0;
        state_d = StReq;
      end
      StReq: begin
        if (loc_ready) begin
          rdata_d  = loc_rdata;
          status_d = loc_err ? STATUS_ERROR : STATUS_COMPLETE;
          state_d  = StAck;
        end else if (cnt_q == CntMax) begin
          status_d = STATUS_TRYAGAIN;
          abort_d  = 1'b1;
          state_d  = StAck;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge nubus_clk or negedge nubus_reset_n) begin
    if (!nubus_reset_n) begin
      state_q   <= StIdle;
      is_read_q <= 1'b0;
      be_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      status_q  <= STATUS_COMPLETE;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_read_q <= is_read_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      status_q  <= status_d;
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
    end
  end

  logic in_ack, rd_ok;

  always_comb begin
    in_ack    = (state_q == StAck);
    rd_ok     = in_ack && is_read_q && (status_q == STATUS_COMPLETE);
    ack_o_n   = ~in_ack;
    tmoen     = ~in_ack;
    {tm1_o_n, tm0_o_n} = in_ack ? ~status_q : 2'b11;
    ad_oe_n   = ~rd_ok;
    ad_o_n    = rd_ok ? ~rdata_q : '1;
    loc_valid = (state_q == StReq);
    loc_we    = loc_valid && !is_read_q;
    loc_addr  = addr_q;
    loc_wdata = wdata_q;
    loc_be    = be_q;
    loc_abort = abort_q;
  end

endmodule

// File: tb/tb_nubus_slave_responder.sv
// Scoreboard bench for nubus_slave_responder: expected responses are queued at START
// and popped when ACK appears.
module tb_nubus_slave_responder;

  localparam int unsigned TO = 8;
  localparam int unsigned AW = 22;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  id_n = ~4'h9;
  logic        start_n = 1'b1, ack_n = 1'b1, tm1_n = 1'b1, tm0_n = 1'b1;
  logic [31:0] ad_n = '1;
  logic        loc_ready = 1'b0;
  logic [31:0] loc_rdata = '0;
  logic        loc_err = 1'b0;

  logic          ack_o_n, tm1_o_n, tm0_o_n, tmoen, ad_oe_n, loc_valid, loc_we, loc_abort;
  logic [31:0]   ad_o_n, loc_wdata;
  logic [AW-1:0] loc_addr;
  logic [3:0]    loc_be;

  logic          ack_o_n_b, tm1_o_n_b, tm0_o_n_b, tmoen_b, ad_oe_n_b, loc_valid_b;
  logic          loc_we_b, loc_abort_b;
  logic [31:0]   ad_o_n_b, loc_wdata_b;
  logic [AW-1:0] loc_addr_b;
  logic [3:0]    loc_be_b;

  always #5 clk = ~clk;

  nubus_slave_responder #(.TIMEOUT_CYCLES(TO), .ENABLE_SUPERSLOT(1'b1), .LOC_ADDR_W(AW)) dut (
    .nubus_clk(clk), .nubus_reset_n(rst_n), .id_n(id_n), .start_n(start_n), .ack_n(ack_n),
    .tm1_n(tm1_n), .tm0_n(tm0_n), .ad_n(ad_n), .ack_o_n(ack_o_n), .tm1_o_n(tm1_o_n),
    .tm0_o_n(tm0_o_n), .tmoen(tmoen), .ad_o_n(ad_o_n), .ad_oe_n(ad_oe_n),
    .loc_valid(loc_valid), .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
    .loc_be(loc_be), .loc_ready(loc_ready), .loc_rdata(loc_rdata), .loc_err(loc_err),
    .loc_abort(loc_abort)
  );

  nubus_slave_responder #(.TIMEOUT_CYCLES(TO), .ENABLE_SUPERSLOT(1'b0), .LOC_ADDR_W(AW)) dut_b (
    .nubus_clk(clk), .nubus_reset_n(rst_n), .id_n(id_n), .start_n(start_n), .ack_n(ack_n),
    .tm1_n(tm1_n), .tm0_n(tm0_n), .ad_n(ad_n), .ack_o_n(ack_o_n_b), .tm1_o_n(tm1_o_n_b),
    .tm0_o_n(tm0_o_n_b), .tmoen(tmoen_b), .ad_o_n(ad_o_n_b), .ad_oe_n(ad_oe_n_b),
    .loc_valid(loc_valid_b), .loc_we(loc_we_b), .loc_addr(loc_addr_b),
    .loc_wdata(loc_wdata_b), .loc_be(loc_be_b), .loc_ready(loc_ready),
    .loc_rdata(loc_rdata), .loc_err(loc_err), .loc_abort(loc_abort_b)
  );

  typedef struct packed {
    logic [1:0]  tm_n;
    logic        ad_oe_n;
    logic [31:0] ad_n;
  } resp_t;

  resp_t exp_q[$];
  resp_t e;
  int    checks = 0;
  int    errors = 0;

  int            obs_lat, obs_abort_cnt;
  logic          obs_ack, obs_ack_after, obs_valid_seen, obs_we, obs_b_seen, obs_abort_at_ack;
  resp_t         obs_resp;
  logic [AW-1:0] obs_addr;
  logic [3:0]    obs_be;
  logic [31:0]   obs_wdata;

  // Drives one START and watches the response; ready_k is the cycle loc_ready rises.
  task automatic run_xfer(input logic [31:0] a, input logic rd, input logic bm,
                          input logic attn, input logic [31:0] wdata, input int ready_k,
                          input int max_k);
    obs_lat = 0; obs_abort_cnt = 0; obs_ack = 0; obs_valid_seen = 0; obs_we = 0;
    obs_b_seen = 0; obs_abort_at_ack = 0; obs_resp = '1; obs_addr = '0; obs_be = '0;
    obs_wdata = '0;
    @(negedge clk);
    start_n = 1'b0; ack_n = ~attn; ad_n = ~a; tm1_n = ~rd; tm0_n = ~bm;
    loc_ready = (ready_k == 0);
    for (int k = 1; k <= max_k; k++) begin
      @(negedge clk);
      if (loc_valid && !obs_valid_seen) begin
        obs_valid_seen = 1; obs_we = loc_we; obs_addr = loc_addr; obs_be = loc_be;
        obs_wdata = loc_wdata;
      end
      if (loc_abort) obs_abort_cnt++;
      if (loc_valid_b || !ack_o_n_b) obs_b_seen = 1;
      if (!ack_o_n) begin
        obs_ack = 1; obs_lat = k; obs_abort_at_ack = loc_abort;
        obs_resp = {tm1_o_n, tm0_o_n, ad_oe_n, ad_o_n};
        break;
      end
      if (k == 1) begin
        start_n = 1'b1; ack_n = 1'b1; tm1_n = 1'b1; tm0_n = 1'b1; ad_n = ~wdata;
      end
      if (k == 2) ad_n = '1;
      if (k >= ready_k) loc_ready = 1'b1;
    end
    start_n = 1'b1; ack_n = 1'b1; tm1_n = 1'b1; tm0_n = 1'b1; ad_n = '1; loc_ready = 1'b0;
    @(negedge clk);
    obs_ack_after = ack_o_n;
    if (loc_abort) obs_abort_cnt++;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({ack_o_n, tmoen, tm1_o_n, tm0_o_n, ad_oe_n} !== 5'b11111) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 11111", {ack_o_n, tmoen, tm1_o_n, tm0_o_n, ad_oe_n});
    end
    checks++;
    if ({loc_valid, loc_abort} !== 2'b00) begin
      errors++; $display("FAIL reset_loc got %b want 00", {loc_valid, loc_abort});
    end
    checks++;
    if (loc_addr !== '0 || loc_wdata !== '0 || loc_be !== '0) begin
      errors++;
      $display("FAIL reset_regs got addr %h wdata %h be %h want zeros", loc_addr, loc_wdata, loc_be);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word_read();
    loc_rdata = 32'hDEADBEEF;
    exp_q.push_back('{tm_n: 2'b11, ad_oe_n: 1'b0, ad_n: ~32'hDEADBEEF});
    run_xfer(32'hF900_0010, 1'b1, 1'b0, 1'b0, 32'h0, 0, 20);
    checks++;
    if (!obs_ack || obs_lat != 2) begin
      errors++; $display("FAIL word_read_lat got %0d (ack %b) want 2", obs_lat, obs_ack);
    end
    checks++;
    if (obs_addr !== 22'h4 || obs_be !== 4'hF || obs_we !== 1'b0) begin
      errors++;
      $display("FAIL word_read_req got addr %h be %h we %b want 000004 f 0", obs_addr, obs_be, obs_we);
    end
    if (obs_ack) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_resp.tm_n !== e.tm_n || obs_resp.ad_oe_n !== e.ad_oe_n || obs_resp.ad_n !== e.ad_n) begin
        errors++; $display("FAIL word_read_resp got %h want %h", obs_resp, e);
      end
    end
    checks++;
    if (obs_ack_after !== 1'b1) begin
      errors++; $display("FAIL word_read_ack_len got %b want 1", obs_ack_after);
    end
  endtask

  task automatic test_byte_write();
    exp_q.push_back('{tm_n: 2'b11, ad_oe_n: 1'b1, ad_n: '1});
    run_xfer(32'hF900_0003, 1'b0, 1'b1, 1'b0, 32'h0000_00A5, 0, 20);
    checks++;
    if (!obs_ack || obs_lat != 3) begin
      errors++; $display("FAIL byte_write_lat got %0d (ack %b) want 3", obs_lat, obs_ack);
    end
    checks++;
    if (obs_we !== 1'b1 || obs_be !== 4'h8 || obs_wdata !== 32'h0000_00A5) begin
      errors++;
      $display("FAIL byte_write_req got we %b be %h wdata %h want 1 8 000000a5",
               obs_we, obs_be, obs_wdata);
    end
    if (obs_ack) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_resp.tm_n !== e.tm_n || obs_resp.ad_oe_n !== e.ad_oe_n) begin
        errors++; $display("FAIL byte_write_resp got %h want %h", obs_resp, e);
      end
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic        rd;
    logic        bm;
    int          rk;
    logic [3:0]  be;
    int          lat;
  } vec_t;

  task automatic test_xfer_types();
    vec_t v[4];
    v[0] = '{a: 32'hF900_0102, rd: 1'b0, bm: 1'b0, rk: 0, be: 4'h3, lat: 3};
    v[1] = '{a: 32'hF900_0103, rd: 1'b0, bm: 1'b0, rk: 0, be: 4'hC, lat: 3};
    v[2] = '{a: 32'hF900_0105, rd: 1'b1, bm: 1'b1, rk: 0, be: 4'h2, lat: 2};
    v[3] = '{a: 32'hF900_0200, rd: 1'b1, bm: 1'b0, rk: 4, be: 4'hF, lat: 5};
    for (int i = 0; i < 4; i++) begin
      logic [31:0] wd;
      logic [31:0] a;
      wd = 32'h1234_0000 + i;
      a = v[i].a;
      loc_rdata = 32'h5A00_0000 + i;
      exp_q.push_back('{tm_n: 2'b11, ad_oe_n: ~v[i].rd, ad_n: ~loc_rdata});
      run_xfer(v[i].a, v[i].rd, v[i].bm, 1'b0, wd, v[i].rk, 20);
      checks++;
      if (!obs_ack || obs_lat != v[i].lat) begin
        errors++; $display("FAIL types%0d_lat got %0d want %0d", i, obs_lat, v[i].lat);
      end
      checks++;
      if (obs_be !== v[i].be || obs_addr !== a[AW+1:2] || obs_we !== ~v[i].rd ||
          (!v[i].rd && obs_wdata !== wd)) begin
        errors++;
        $display("FAIL types%0d_req got be %h addr %h we %b wdata %h want %h %h %b %h",
                 i, obs_be, obs_addr, obs_we, obs_wdata, v[i].be, a[AW+1:2], ~v[i].rd, wd);
      end
      if (obs_ack) begin
        e = exp_q.pop_front();
        checks++;
        if (obs_resp.tm_n !== e.tm_n || obs_resp.ad_oe_n !== e.ad_oe_n ||
            (!e.ad_oe_n && obs_resp.ad_n !== e.ad_n)) begin
          errors++; $display("FAIL types%0d_resp got %h want %h", i, obs_resp, e);
        end
      end
    end
  endtask

  task automatic test_reserved_and_err();
    exp_q.push_back('{tm_n: 2'b10, ad_oe_n: 1'b1, ad_n: '1});
    run_xfer(32'hF900_0001, 1'b1, 1'b0, 1'b0, 32'h0, 0, 20);
    checks++;
    if (!obs_ack || obs_lat != 1 || obs_valid_seen !== 1'b0) begin
      errors++;
      $display("FAIL reserved got lat %0d valid %b want lat 1 valid 0", obs_lat, obs_valid_seen);
    end
    if (obs_ack) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_resp.tm_n !== e.tm_n || obs_resp.ad_oe_n !== e.ad_oe_n) begin
        errors++; $display("FAIL reserved_resp got %h want %h", obs_resp, e);
      end
    end
    loc_err = 1'b1;
    exp_q.push_back('{tm_n: 2'b10, ad_oe_n: 1'b1, ad_n: '1});
    run_xfer(32'hF900_0040, 1'b1, 1'b0, 1'b0, 32'h0, 0, 20);
    loc_err = 1'b0;
    if (obs_ack) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_resp.tm_n !== e.tm_n || obs_resp.ad_oe_n !== e.ad_oe_n) begin
        errors++; $display("FAIL loc_err_resp got %h want %h", obs_resp, e);
      end
    end else begin
      checks++; errors++; $display("FAIL loc_err_ack got none want ack");
    end
  endtask

  task automatic test_timeout();
    exp_q.push_back('{tm_n: 2'b00, ad_oe_n: 1'b1, ad_n: '1});
    run_xfer(32'hF900_0080, 1'b1, 1'b0, 1'b0, 32'h0, 1000, 30);
    checks++;
    if (!obs_ack || obs_lat != TO + 1) begin
      errors++; $display("FAIL timeout_lat got %0d want %0d", obs_lat, TO + 1);
    end
    checks++;
    if (obs_abort_at_ack !== 1'b1 || obs_abort_cnt != 1) begin
      errors++;
      $display("FAIL timeout_abort got at_ack %b pulses %0d want 1 1", obs_abort_at_ack, obs_abort_cnt);
    end
    if (obs_ack) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_resp.tm_n !== e.tm_n || obs_resp.ad_oe_n !== e.ad_oe_n) begin
        errors++; $display("FAIL timeout_resp got %h want %h", obs_resp, e);
      end
    end
  endtask

  task automatic test_ignored();
    run_xfer(32'hF900_0000, 1'b1, 1'b0, 1'b1, 32'h0, 0, 12);
    checks++;
    if (obs_ack || obs_valid_seen) begin
      errors++; $display("FAIL attention got ack %b valid %b want 0 0", obs_ack, obs_valid_seen);
    end
    run_xfer(32'hFA00_0000, 1'b1, 1'b0, 1'b0, 32'h0, 0, 12);
    checks++;
    if (obs_ack || obs_valid_seen) begin
      errors++; $display("FAIL other_slot got ack %b valid %b want 0 0", obs_ack, obs_valid_seen);
    end
  endtask

  task automatic test_superslot();
    loc_rdata = 32'hCAFE_F00D;
    exp_q.push_back('{tm_n: 2'b11, ad_oe_n: 1'b0, ad_n: ~32'hCAFE_F00D});
    run_xfer(32'h9000_0000, 1'b1, 1'b0, 1'b0, 32'h0, 0, 20);
    checks++;
    if (!obs_ack || obs_addr !== '0) begin
      errors++; $display("FAIL superslot got ack %b addr %h want 1 000000", obs_ack, obs_addr);
    end
    checks++;
    if (obs_b_seen !== 1'b0) begin
      errors++; $display("FAIL superslot_disabled got activity %b want 0", obs_b_seen);
    end
    if (obs_ack) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_resp.tm_n !== e.tm_n || obs_resp.ad_oe_n !== e.ad_oe_n || obs_resp.ad_n !== e.ad_n) begin
        errors++; $display("FAIL superslot_resp got %h want %h", obs_resp, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    int acks;
    acks = 0;
    @(negedge clk);
    start_n = 1'b0; ad_n = ~32'hF900_0020; tm1_n = 1'b0; tm0_n = 1'b1; loc_ready = 1'b0;
    @(negedge clk);
    start_n = 1'b1; ad_n = '1; tm1_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (loc_valid !== 1'b1) begin
      errors++; $display("FAIL mid_req got valid %b want 1", loc_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (loc_valid !== 1'b0 || loc_valid_b !== 1'b0 || ack_o_n !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got valid %b valid_b %b ack_n %b want 0 0 1",
               loc_valid, loc_valid_b, ack_o_n);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (!ack_o_n) acks++;
    end
    rst_n = 1'b1;
    checks++;
    if (acks != 0) begin
      errors++; $display("FAIL mid_reset_ack got %0d acks want 0", acks);
    end
    loc_rdata = 32'h0BAD_CAFE;
    exp_q.push_back('{tm_n: 2'b11, ad_oe_n: 1'b0, ad_n: ~32'h0BAD_CAFE});
    run_xfer(32'hF900_0024, 1'b1, 1'b0, 1'b0, 32'h0, 0, 20);
    checks++;
    if (!obs_ack || obs_lat != 2 || obs_addr !== 22'h9) begin
      errors++;
      $display("FAIL post_reset got ack %b lat %0d addr %h want 1 2 000009", obs_ack, obs_lat, obs_addr);
    end
    if (obs_ack) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_resp.tm_n !== e.tm_n || obs_resp.ad_oe_n !== e.ad_oe_n || obs_resp.ad_n !== e.ad_n) begin
        errors++; $display("FAIL post_reset_resp got %h want %h", obs_resp, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_byte_write();
    test_xfer_types();
    test_reserved_and_err();
    test_timeout();
    test_ignored();
    test_superslot();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_left got %0d entries want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
